// File: rtl/canvas_writer.sv
// rtl/canvas_writer.sv - 32x32 binary canvas with draw/erase/clear/snapshot commands
// Optional 3x3 brush enabled by defining CANVAS_BRUSH3_EN.
module canvas_writer #(
  parameter int IMG_DIM = 32,
  parameter int COORD_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [COORD_W-1:0]           cmd_x,
  input  logic [COORD_W-1:0]           cmd_y,
  output logic [IMG_DIM*IMG_DIM-1:0]   canvas,
  output logic [IMG_DIM*IMG_DIM-1:0]   snap_image,
  output logic                         snap_valid,
  input  logic                         snap_ready,
  output logic                         busy,
  output logic [10:0]                  pixel_count
);

  localparam int NPIX = IMG_DIM * IMG_DIM;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SNAP  = 2'b11;

  typedef enum logic [1:0] {IDLE, CLEAR, SNAP} state_t;

  state_t             state;
  logic [COORD_W-1:0] row;
  logic [NPIX-1:0]    mask;
  logic [NPIX-1:0]    changed;
  logic [10:0]        delta;

`ifdef CANVAS_BRUSH3_EN
  // 3x3 block centred on (x, y); neighbours outside the canvas are dropped, never wrapped.
  function automatic logic [NPIX-1:0] brush_mask(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    logic [NPIX-1:0] m;
    int xx;
    int yy;
    m = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = int'(x) + dx;
        yy = int'(y) + dy;
        if (xx >= 0 && xx < IMG_DIM && yy >= 0 && yy < IMG_DIM)
          m[10'(yy * IMG_DIM + xx)] = 1'b1;
      end
    end
    return m;
  endfunction
`endif

  always_comb begin
`ifdef CANVAS_BRUSH3_EN
    mask = brush_mask(cmd_x, cmd_y);
`else
    mask = '0;
    mask[{cmd_y, cmd_x}] = 1'b1;
`endif
    // Only bits that actually flip contribute to the count change.
    changed = mask & ((cmd_op == OP_ERASE) ? canvas : ~canvas);
    delta   = 11'($countones(changed));
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row         <= '0;
      canvas      <= '0;
      snap_image  <= '0;
      snap_valid  <= 1'b0;
      pixel_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_DRAW: begin
                canvas      <= canvas | mask;
                pixel_count <= pixel_count + delta;
              end
              OP_ERASE: begin
                canvas      <= canvas & ~mask;
                pixel_count <= pixel_count - delta;
              end
              OP_CLEAR: begin
                row   <= '0;
                state <= CLEAR;
              end
              OP_SNAP: begin
                snap_image <= canvas;
                snap_valid <= 1'b1;
                state      <= SNAP;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          // One row per cycle; the count stays at its old value until the sweep ends.
          canvas[{row, {COORD_W{1'b0}}} +: IMG_DIM] <= '0;
          row <= row + 1'b1;
          if (row == COORD_W'(IMG_DIM - 1)) begin
            pixel_count <= '0;
            state       <= IDLE;
          end
        end
        SNAP: begin
          if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/canvas_writer.md
# canvas_writer

Stateful producer of the 32x32 binary handwriting bitmap that feeds the dilation/pre-processing stage ahead of the DNN. It accepts draw, erase, clear and snapshot commands over a valid/ready handshake and maintains the live canvas. On a snapshot it freezes a copy of the canvas and offers it downstream over a second valid/ready handshake. Pixel index is row-major: bit `y*32 + x`, so bit 0 is top-left (x=0, y=0) and bit 1023 is bottom-right.

## Interface
- `IMG_DIM`, default 32: canvas side length; only 32 is supported.
- `COORD_W`, default 5: coordinate width, log2(IMG_DIM).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted on an edge where `cmd_valid` and `cmd_ready` are both high.
- `cmd_op` input 2: 00 draw, 01 erase, 10 clear, 11 snapshot.
- `cmd_x` input 5: column, 0..31.
- `cmd_y` input 5: row, 0..31.
- `canvas` output 1024: live bitmap, registered.
- `snap_image` output 1024: frozen bitmap, stable while `snap_valid` is high.
- `snap_valid` output 1: snapshot offered.
- `snap_ready` input 1: downstream accepts the snapshot.
- `busy` output 1: FSM is not in IDLE.
- `pixel_count` output 11: number of set bits in `canvas`, 0..1024.

## Operation
- **FSM states:** IDLE, CLEAR, SNAP.
- **Outputs by state:**
  - `cmd_ready` = (state == IDLE), combinational.
  - `busy` = the inverse of `cmd_ready`.
- **IDLE, draw:** sets the target pixel(s). `pixel_count` increases by the number of bits that go 0→1. Stays in IDLE.
- **IDLE, erase:** clears the target pixel(s). `pixel_count` decreases by the number of bits that go 1→0. Stays in IDLE.
- **IDLE, clear:** goes to CLEAR and loads the row counter with 0.
- **CLEAR:**
  - Each cycle zeroes one full row (row counter r, bits r*32..r*32+31), then increments r.
  - After row 31, goes back to IDLE and `pixel_count` becomes 0.
  - During the sweep `pixel_count` is held at its pre-clear value.
- **IDLE, snapshot:**
  - `snap_image` <= `canvas` (the value before this edge).
  - `snap_valid` <= 1; go to SNAP.
- **SNAP:** holds `snap_image` and `snap_valid` steady. On an edge where `snap_valid` and `snap_ready` are both high: `snap_valid` <= 0 and go to IDLE. `canvas` is untouched.
- **Coordinates:** always in range because of the 5-bit width. There is no wrap-around: a brush is clipped at x=0, x=31, y=0 and y=31.
- **Reset** (any time, including mid-CLEAR or mid-SNAP): state IDLE; `canvas`, `snap_image`, row counter and `pixel_count` all 0; `snap_valid` 0. Because of the IDLE state, `cmd_ready` reads 1 and `busy` reads 0 while `rst_n` is low.

## Timing
- **Draw/erase:** accepted at edge N; `canvas` and `pixel_count` are updated at the output after edge N. Throughput is one command per cycle.
- **Clear:** accepted at edge N; row k is cleared at edge N+1+k; `cmd_ready` is low from after edge N until after edge N+32. Total 32 busy cycles.
- **Snapshot:**
  - `snap_valid` rises after the acceptance edge.
  - If `snap_ready` is held high, `snap_valid` lasts exactly one cycle and `cmd_ready` returns one cycle after acceptance.
  - `snap_ready` is ignored while `snap_valid` is 0.
- **Back-to-back draw then snapshot:** the snapshot contains the draw.
- **`pixel_count` width:** 11 bits. The full count of 1024 is reachable only through draws and must not overflow.

## Configuration
- **Macro `CANVAS_BRUSH3_EN`:**
  - Defined: draw and erase act on the 3x3 block centred at (x, y), clipped at the edges (4 pixels at a corner, 6 at an edge, 9 inside). The `pixel_count` delta is the popcount of the changed bits, 0..9.
  - Undefined: draw and erase act on the single pixel (x, y), and the delta is 0 or 1.

## Test plan
- **Reset state:** reset, then draw (3,2) → `canvas` has only bit 67 set, `pixel_count`=1. Draw (3,2) again → `pixel_count` stays 1. Erase (3,2) → `pixel_count`=0.
- **Clear sweep:** draw (0,0), (31,0) and (31,31), then clear → `cmd_ready` is low for 32 cycles; bits 0 and 31 clear one edge after acceptance, bit 1023 clears 32 edges after; `pixel_count`=0 after the sweep.
- **Snapshot backpressure:** draw (5,5), snapshot with `snap_ready`=0 for 10 cycles → `snap_image` bit 165 is set and stable, and a draw (6,6) offered meanwhile is not accepted. Raise `snap_ready` → `snap_valid` drops after one edge, then draw (6,6) is accepted.
- **Reset mid-operation:** assert `rst_n`=0 at clear row 10 and again mid-SNAP → all outputs return to reset values immediately; `cmd_ready`=1.
- **Brush (`CANVAS_BRUSH3_EN`):** draw (0,0) → bits 0, 1, 32, 33 set, `pixel_count`=4. Draw (1,1) → `pixel_count`=9. Nothing wraps into bits 31 or 992.
